// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared funct3/wb_select encodings, FSM state type and access-size helpers
package rv32i_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    // Everything the stage must hold while a memory access is outstanding
    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] pc4;
        logic [31:0] immu;
        logic [31:0] pcimm;
        logic [2:0]  funct3;
        logic [4:0]  addr_wb;
        logic        werf;
        logic [1:0]  wb_sel;
        logic        load;
    } fields_t;

    // Unknown load encodings fall into the word bucket
    function automatic size_t mem_size(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? SZ_B : f3[1:0] == 2'b01 ? SZ_H : SZ_W;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (mem_size(f3) == SZ_H && a[0]) || (mem_size(f3) == SZ_W && a != 2'b00);
    endfunction

endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword lane of a read word and sign/zero extends it
import rv32i_mem_pkg::*;

module load_extend (
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    // Halfword lane uses addr[1] only; word ignores the low address bits
    always_comb begin
        b      = 8'(rdata >> {addr, 3'b000});
        h      = addr[1] ? rdata[31:16] : rdata[15:0];
        result = funct3 == F3_B  ? {{24{b[7]}}, b} :
                 funct3 == F3_H  ? {{16{h[15]}}, h} :
                 funct3 == F3_BU ? {24'b0, b} :
                 funct3 == F3_HU ? {16'b0, h} : rdata;
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I memory stage with IDLE/REQ/RESP handshake FSM and wait timeout; MISALIGN_TRAP_EN enables misaligned-access trapping
import rv32i_mem_pkg::*;

module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  addr_wb_in,
    input  logic        werf_enable_in,
    input  logic [1:0]  wb_select_in,
    input  logic [31:0] pc_plus_4_in,
    input  logic [31:0] immu_in,
    input  logic [31:0] pc_plus_immu_in,
    output logic        stall_out,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        valid_out,
    output logic [31:0] read_mem_out,
    output logic [31:0] alu_result_out,
    output logic [31:0] pc_plus_4_out,
    output logic [31:0] immu_out,
    output logic [31:0] pc_plus_immu_out,
    output logic        load_out,
    output logic [1:0]  wb_select_out,
    output logic [4:0]  addr_wb_out,
    output logic        werf_enable_out,
    output logic        bus_err_out,
    output logic        misalign_out
);

    state_t      state;
    logic [7:0]  cnt;
    fields_t     r, in_f, cur;
    size_t       sz;
    logic [31:0] ext;
    logic        idle, mem_op, mis, pass, go, req_done, to_resp, resp_done, abort;

    assign in_f = '{alu: alu_result_in, sdata: store_data_in, pc4: pc_plus_4_in,
                    immu: immu_in, pcimm: pc_plus_immu_in, funct3: funct3_in,
                    addr_wb: addr_wb_in, werf: werf_enable_in, wb_sel: wb_select_in,
                    load: mem_read_in};

    assign idle   = state == S_IDLE;
    assign mem_op = mem_read_in | mem_write_in;

`ifdef MISALIGN_TRAP_EN
    assign mis = mem_op & misaligned(funct3_in, alu_result_in[1:0]);
`else
    assign mis = 1'b0;
`endif

    assign pass      = idle & valid_in & (~mem_op | mis);
    assign go        = idle & valid_in & mem_op & ~mis;
    assign req_done  = state == S_REQ & dmem_ready & ~r.load;
    assign to_resp   = state == S_REQ & dmem_ready & r.load;
    assign resp_done = state == S_RESP & dmem_rvalid;
    assign abort     = cnt == 8'(TIMEOUT) &
                       ((state == S_REQ & ~dmem_ready) | (state == S_RESP & ~dmem_rvalid));

    assign valid_out = pass | req_done | resp_done | abort;
    assign stall_out = go | (~idle & ~valid_out);

    // In IDLE the result is the live upstream beat; otherwise the latched transaction
    assign cur = idle ? in_f : r;

    assign alu_result_out   = valid_out ? cur.alu : '0;
    assign pc_plus_4_out    = valid_out ? cur.pc4 : '0;
    assign immu_out         = valid_out ? cur.immu : '0;
    assign pc_plus_immu_out = valid_out ? cur.pcimm : '0;
    assign wb_select_out    = valid_out ? cur.wb_sel : '0;
    assign addr_wb_out      = valid_out ? cur.addr_wb : '0;
    assign misalign_out     = pass & mis;
    assign werf_enable_out  = valid_out & cur.werf & ~abort & ~misalign_out;
    assign bus_err_out      = abort;
    assign load_out         = resp_done;
    assign read_mem_out     = resp_done ? ext : '0;

    assign sz         = mem_size(r.funct3);
    assign dmem_req   = state == S_REQ;
    assign dmem_we    = dmem_req & ~r.load;
    assign dmem_addr  = {r.alu[31:2], 2'b00};
    assign dmem_wstrb = ~dmem_we ? 4'b0000 :
                        sz == SZ_B ? 4'b0001 << r.alu[1:0] :
                        sz == SZ_H ? (r.alu[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign dmem_wdata = sz == SZ_B ? {4{r.sdata[7:0]}} :
                        sz == SZ_H ? {2{r.sdata[15:0]}} : r.sdata;

    load_extend u_ext (
        .rdata  (dmem_rdata),
        .addr   (r.alu[1:0]),
        .funct3 (r.funct3),
        .result (ext)
    );

    // Transaction FSM: latch on issue, restart the wait count per phase, return to IDLE on any completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            r     <= '0;
        end else if (go) begin
            state <= S_REQ;
            cnt   <= '0;
            r     <= in_f;
        end else if (to_resp) begin
            state <= S_RESP;
            cnt   <= '0;
        end else if (valid_out) begin
            state <= S_IDLE;
        end else if (!idle) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule
